count_checker: RTL and testbench

Synthesizable in-line monitor that consumes the count stream produced by a counter under test, such as the 4-bit ripple counter. It predicts the next count value every clock and flags any deviation. It is the receiving/checking end of the counter's output interface and moves self-checking from the bench into RTL, so it can be used on silicon or FPGA.

---
 rtl/count_checker.sv | 158 +++++++++++++++
 tb/tb_count_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// In-line monitor for a counter's output stream: predicts the next count, locks after
// LOCK_CYCLES clean increments and flags/counts deviations. CNT_CHK_DIR_EN adds dir_i (up/down).
module count_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned ERR_CNT_W   = 8,
    parameter int unsigned LOCK_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
`ifdef CNT_CHK_DIR_EN
    input  logic                 dir_i,
`endif
    input  logic                 clear_i,
    input  logic [WIDTH-1:0]     count_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [WIDTH-1:0]     expected_o
);

    localparam int unsigned        MATCH_W  = $clog2(LOCK_CYCLES + 1);
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       expected_q, expected_d;
    logic [MATCH_W-1:0]     match_q, match_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   err_q, err_d;
    logic                   locked_q, locked_d;

    logic                   dir_cur;
    logic                   dir_chg;
    logic                   hit;
    logic [WIDTH-1:0]       seed_val;
    logic [MATCH_W-1:0]     match_inc;
    logic [ERR_CNT_W-1:0]   err_base;

`ifdef CNT_CHK_DIR_EN
    logic dir_q;

    // Direction is tracked every cycle so a flip while locked is seen as a resync, not an error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q <= 1'b1;
        end else begin
            dir_q <= dir_i;
        end
    end

    assign dir_cur = dir_i;
    assign dir_chg = (dir_i != dir_q);
`else
    assign dir_cur = 1'b1;
    assign dir_chg = 1'b0;
`endif

    always_comb begin
        hit       = (count_i == expected_q);
        match_inc = match_q + 1'b1;
        if (dir_cur) begin
            seed_val = count_i + 1'b1;
        end else begin
            seed_val = count_i - 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            expected_q <= '0;
            match_q    <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = SYNC;
                SYNC: begin
                    if (hit && (match_inc == LOCK_TGT)) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (dir_chg || !hit) begin
                        state_d = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath/output logic; every enabled cycle re-seeds the prediction from the sample.
    always_comb begin
        expected_d = expected_q;
        match_d    = match_q;
        err_d      = 1'b0;
        err_base   = clear_i ? '0 : err_cnt_q;
        if (en_i) begin
            unique case (state_q)
                IDLE: begin
                    expected_d = seed_val;
                    match_d    = '0;
                end
                SYNC: begin
                    expected_d = seed_val;
                    match_d    = hit ? match_inc : '0;
                end
                LOCKED: begin
                    expected_d = seed_val;
                    if (dir_chg || !hit) begin
                        match_d = '0;
                        err_d   = !dir_chg;
                    end
                end
                default: begin
                    expected_d = expected_q;
                    match_d    = '0;
                end
            endcase
        end
        // Clear takes effect before the increment so a same-cycle mismatch leaves a count of one.
        err_cnt_d = err_base;
        if (err_d && !(&err_base)) begin
            err_cnt_d = err_base + 1'b1;
        end
        locked_d = (state_d == LOCKED);
    end

    assign locked_o   = locked_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;
    assign expected_o = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed self-checking bench for count_checker (WIDTH=4, ERR_CNT_W=8, LOCK_CYCLES=2).
module tb_count_checker;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic       dir_i;
    logic       clear_i;
    logic [3:0] count_i;
    logic       locked_o;
    logic       err_o;
    logic [7:0] err_cnt_o;
    logic [3:0] expected_o;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    always #5 clk_i = ~clk_i;

    count_checker #(
        .WIDTH       (4),
        .ERR_CNT_W   (8),
        .LOCK_CYCLES (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
`ifdef CNT_CHK_DIR_EN
        .dir_i      (dir_i),
`endif
        .clear_i    (clear_i),
        .count_i    (count_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o),
        .expected_o (expected_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step(input logic [3:0] c);
        count_i = c;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni  = 1'b0;
        en_i    = 1'b0;
        dir_i   = 1'b1;
        clear_i = 1'b0;
        count_i = 4'd0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_locked", locked_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_err_cnt", err_cnt_o, 0);
        chk("rst_expected", expected_o, 0);

        // Clean up-count 0..15: lock after the sample 2, wrap predicts 0.
        rst_ni = 1'b1;
        en_i   = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(4'(k));
            chk("t1_locked", locked_o, (k >= 2) ? 1 : 0);
            chk("t1_err", err_o, 0);
            chk("t1_expected", expected_o, (k + 1) % 16);
        end
        for (int k = 0; k < 9; k++) step(4'(k));
        chk("t1_locked_after_wrap", locked_o, 1);
        chk("t1_err_cnt", err_cnt_o, 0);

        // Inject 5 where 9 is expected, then relock on 6,7.
        step(4'd5);
        chk("t2_err", err_o, 1);
        chk("t2_err_cnt", err_cnt_o, 1);
        chk("t2_locked", locked_o, 0);
        chk("t2_expected", expected_o, 6);
        step(4'd6);
        chk("t2_err_clear", err_o, 0);
        chk("t2_locked6", locked_o, 0);
        step(4'd7);
        chk("t2_relock7", locked_o, 1);
        step(4'd8);
        chk("t2_locked8", locked_o, 1);

        // Saturation: every "4,5,3" triple relocks then mismatches once.
        step(4'd3);
        chk("t3_err_cnt2", err_cnt_o, 2);
        chk("t3_expected", expected_o, 4);
        for (int n = 1; n <= 300; n++) begin
            step(4'd4);
            step(4'd5);
            step(4'd3);
            if (n == 100) chk("t3_err_cnt_102", err_cnt_o, 102);
            if (n == 253) chk("t3_err_cnt_255", err_cnt_o, 255);
        end
        chk("t3_sat", err_cnt_o, 255);
        chk("t3_err_pulse", err_o, 1);
        chk("t3_locked", locked_o, 0);

        // Clear alone, build up to 4, then clear with a same-cycle mismatch.
        clear_i = 1'b1;
        step(4'd4);
        clear_i = 1'b0;
        chk("t4_clear", err_cnt_o, 0);
        chk("t4_clear_err", err_o, 0);
        step(4'd5);
        chk("t4_lock", locked_o, 1);
        step(4'd3);
        for (int n = 0; n < 3; n++) begin
            step(4'd4);
            step(4'd5);
            step(4'd3);
        end
        chk("t4_err_cnt4", err_cnt_o, 4);
        step(4'd4);
        step(4'd5);
        clear_i = 1'b1;
        step(4'd3);
        clear_i = 1'b0;
        chk("t4_clear_and_err_cnt", err_cnt_o, 1);
        chk("t4_clear_and_err", err_o, 1);

        // Enable drop: unlock, keep the error count, recapture on re-enable.
        step(4'd4);
        step(4'd5);
        chk("en_locked_before", locked_o, 1);
        en_i = 1'b0;
        step(4'd9);
        chk("en_off_locked", locked_o, 0);
        chk("en_off_err", err_o, 0);
        chk("en_off_err_cnt", err_cnt_o, 1);
        en_i = 1'b1;
        step(4'd9);
        chk("en_on_locked", locked_o, 0);
        chk("en_on_expected", expected_o, 10);
        step(4'd10);
        step(4'd11);
        chk("en_relock", locked_o, 1);

        // Asynchronous reset between edges.
        #3;
        rst_ni = 1'b0;
        #1;
        chk("t5_locked", locked_o, 0);
        chk("t5_err", err_o, 0);
        chk("t5_err_cnt", err_cnt_o, 0);
        chk("t5_expected", expected_o, 0);
        #2;
        rst_ni = 1'b1;
        step(4'd10);
        chk("t5_capture_locked", locked_o, 0);
        chk("t5_capture_expected", expected_o, 11);
        step(4'd11);
        chk("t5_locked11", locked_o, 0);
        step(4'd12);
        chk("t5_relock", locked_o, 1);

`ifdef CNT_CHK_DIR_EN
        en_i  = 1'b0;
        dir_i = 1'b0;
        step(4'd0);
        en_i = 1'b1;
        step(4'd2);
        chk("t6_expected1", expected_o, 1);
        step(4'd1);
        chk("t6_locked1", locked_o, 0);
        step(4'd0);
        chk("t6_lock", locked_o, 1);
        chk("t6_expected15", expected_o, 15);
        step(4'd15);
        chk("t6_err15", err_o, 0);
        step(4'd14);
        chk("t6_err14", err_o, 0);
        chk("t6_locked14", locked_o, 1);
        dir_i = 1'b1;
        step(4'd15);
        chk("t6_dir_locked", locked_o, 0);
        chk("t6_dir_err", err_o, 0);
        chk("t6_dir_err_cnt", err_cnt_o, 0);
        chk("t6_dir_expected", expected_o, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
